// File: rtl/demux8_bit_3_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux8_bit_3_buf_pkg
// Description : Shared select encoding, default widths and the select decode
//               helper for the buffered 1-to-3 byte distributor.
// Revision    : 1.0 - initial release
// ============================================================================
package demux8_bit_3_buf_pkg;

    // Default widths
    localparam int c_WIDTH_DEF = 8;
    localparam int c_CNT_W_DEF = 8;

    // Number of consumer ports and their slot indices
    localparam int c_NUM_PORTS = 3;
    localparam int c_PORT_B    = 0;
    localparam int c_PORT_C    = 1;
    localparam int c_PORT_D    = 2;

    // Select encoding as {s2,s1}. The lsb of c_SEL_D is a don't-care: s2
    // alone picks port d, matching the mux (h = s2 ? d : s1 ? c : b).
    localparam logic [1:0] c_SEL_B = 2'b00;
    localparam logic [1:0] c_SEL_C = 2'b01;
    localparam logic [1:0] c_SEL_D = 2'b10;

    // One-hot target decode, bit order {d, c, b}
    function automatic logic [2:0] sel_decode(input logic s2, input logic s1);
        logic [1:0] sel;
        logic [2:0] onehot;
        sel    = {s2, s1};
        onehot = 3'b000;
        if (sel[1] == c_SEL_D[1]) begin
            onehot[c_PORT_D] = 1'b1;
        end else if (sel == c_SEL_C) begin
            onehot[c_PORT_C] = 1'b1;
        end else begin
            onehot[c_PORT_B] = 1'b1;
        end
        return onehot;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux8_bit_3_buf_slot.sv
`default_nettype none
// ============================================================================
// Module      : demux_slot
// Description : One-entry holding register with valid/ready output handshake
//               and a completed-transfer counter for one consumer port.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_slot
    import demux8_bit_3_buf_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEF,
    parameter int CNT_W = c_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    input  logic             i_clr_cnt,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [0:0] c_ST_EMPTY = 1'b0;
    localparam logic [0:0] c_ST_FULL  = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_count;
    logic             w_drain;

    assign w_drain = (r_state == c_ST_FULL) && i_ready;

    // Holding register: a load wins over a same-cycle drain so a port can
    // stream one byte per cycle; data is kept while empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_EMPTY;
            r_data  <= '0;
        end else if (i_load) begin
            r_state <= c_ST_FULL;
            r_data  <= i_data;
        end else if (w_drain) begin
            r_state <= c_ST_EMPTY;
        end
    end

    // Drain counter: wraps naturally, clear has priority over increment
    always_ff @(posedge clk) begin
        if (reset || i_clr_cnt) begin
            r_count <= '0;
        end else if (w_drain) begin
            r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_data  = r_data;
    assign o_valid = (r_state == c_ST_FULL);
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/demux8_bit_3_buf.sv
`default_nettype none
// ============================================================================
// Module      : demux8_bit_3_buf
// Description : Buffered 1-to-3 byte distributor. Steers each accepted
//               producer byte to port b, c or d via the {s2,s1} select and
//               holds it in a per-port one-entry register until drained.
// Revision    : 1.0 - initial release
// ============================================================================
module demux8_bit_3_buf
    import demux8_bit_3_buf_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEF,
    parameter int CNT_W = c_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             s1,
    input  logic             s2,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] b_data,
    output logic [WIDTH-1:0] c_data,
    output logic [WIDTH-1:0] d_data,
    output logic             b_valid,
    output logic             c_valid,
    output logic             d_valid,
    input  logic             b_ready,
    input  logic             c_ready,
    input  logic             d_ready,
    output logic [CNT_W-1:0] b_count,
    output logic [CNT_W-1:0] c_count,
    output logic [CNT_W-1:0] d_count,
    input  logic             clr_cnt
);

    logic [2:0]       w_sel;
    logic [2:0]       w_full;
    logic [2:0]       w_rdy;
    logic [2:0]       w_load;
    logic             w_target_full;
    logic             w_target_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_data  [c_NUM_PORTS];
    logic [CNT_W-1:0] w_count [c_NUM_PORTS];

    assign w_sel = sel_decode(s2, s1);
    assign w_rdy = {d_ready, c_ready, b_ready};

    // Only the selected port gates the producer; other ports never stall it.
    assign w_target_full  = |(w_sel & w_full);
    assign w_target_ready = |(w_sel & w_rdy);
    assign in_ready       = ~w_target_full | w_target_ready;

    // Reset is handled inside each slot, so a load during reset is ignored.
    assign w_accept = in_valid & in_ready;
    assign w_load   = {3{w_accept}} & w_sel;

    generate
        for (genvar gi = 0; gi < c_NUM_PORTS; gi++) begin : g_slot
            demux_slot #(
                .WIDTH (WIDTH),
                .CNT_W (CNT_W)
            ) u_slot (
                .clk       (clk),
                .reset     (reset),
                .i_load    (w_load[gi]),
                .i_data    (in_data),
                .i_ready   (w_rdy[gi]),
                .i_clr_cnt (clr_cnt),
                .o_data    (w_data[gi]),
                .o_valid   (w_full[gi]),
                .o_count   (w_count[gi])
            );
        end
    endgenerate

    assign b_data  = w_data[c_PORT_B];
    assign c_data  = w_data[c_PORT_C];
    assign d_data  = w_data[c_PORT_D];
    assign b_valid = w_full[c_PORT_B];
    assign c_valid = w_full[c_PORT_C];
    assign d_valid = w_full[c_PORT_D];
    assign b_count = w_count[c_PORT_B];
    assign c_count = w_count[c_PORT_C];
    assign d_count = w_count[c_PORT_D];

endmodule
`default_nettype wire

// File: tb/tb_demux8_bit_3_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux8_bit_3_buf
// Description : Self-checking bench for demux8_bit_3_buf: directed scenarios
//               plus randomized traffic against a per-port buffer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux8_bit_3_buf;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       s1, s2, in_valid, in_ready;
    logic [7:0] b_data, c_data, d_data;
    logic       b_valid, c_valid, d_valid;
    logic       b_ready, c_ready, d_ready;
    logic [7:0] b_count, c_count, d_count;
    logic       clr_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: each port either holds one byte or is empty; count of drains
    bit       m_full [3];
    bit [7:0] m_data [3];
    int       m_cnt  [3];

    always #5 clk = ~clk;

    demux8_bit_3_buf #(.WIDTH(8), .CNT_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .s1       (s1),
        .s2       (s2),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .b_data   (b_data),
        .c_data   (c_data),
        .d_data   (d_data),
        .b_valid  (b_valid),
        .c_valid  (c_valid),
        .d_valid  (d_valid),
        .b_ready  (b_ready),
        .c_ready  (c_ready),
        .d_ready  (d_ready),
        .b_count  (b_count),
        .c_count  (c_count),
        .d_count  (d_count),
        .clr_cnt  (clr_cnt)
    );

    function automatic int target();
        return s2 ? 2 : (s1 ? 1 : 0);
    endfunction

    function automatic bit port_ready(int p);
        return (p == 0) ? b_ready : (p == 1) ? c_ready : d_ready;
    endfunction

    function automatic logic dut_valid(int p);
        return (p == 0) ? b_valid : (p == 1) ? c_valid : d_valid;
    endfunction

    function automatic logic [7:0] dut_data(int p);
        return (p == 0) ? b_data : (p == 1) ? c_data : d_data;
    endfunction

    function automatic logic [7:0] dut_count(int p);
        return (p == 0) ? b_count : (p == 1) ? c_count : d_count;
    endfunction

    // The producer may hand over a byte when the chosen port has room or
    // is giving its byte away this cycle.
    function automatic bit model_in_ready();
        return !m_full[target()] || port_ready(target());
    endfunction

    // Advance one clock: model consumes the inputs present before the edge
    task automatic tick();
        bit       nf [3];
        bit [7:0] nd [3];
        int       nc [3];
        bit       took;
        took = in_valid && model_in_ready() && !reset;
        for (int p = 0; p < 3; p++) begin
            bit gone;
            gone  = m_full[p] && port_ready(p);
            nf[p] = m_full[p];
            nd[p] = m_data[p];
            if (took && target() == p) begin
                nf[p] = 1'b1;
                nd[p] = in_data;
            end else if (gone) begin
                nf[p] = 1'b0;
            end
            nc[p] = clr_cnt ? 0 : (gone ? (m_cnt[p] + 1) % 256 : m_cnt[p]);
            if (reset) begin
                nf[p] = 1'b0;
                nd[p] = 8'h00;
                nc[p] = 0;
            end
        end
        @(posedge clk);
        for (int p = 0; p < 3; p++) begin
            m_full[p] = nf[p];
            m_data[p] = nd[p];
            m_cnt[p]  = nc[p];
        end
        #1;
    endtask

    task automatic pulse_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        clr_cnt  = 1'b0;
        tick();
        reset    = 1'b0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h5E;
        s1 = 1'b0; s2 = 1'b0;
        b_ready = 1'b0; c_ready = 1'b0; d_ready = 1'b0;
        clr_cnt = 1'b0;
        tick();
        tick();
        for (int p = 0; p < 3; p++) begin
            n_tests++;
            if (dut_valid(p) !== 1'b0) begin
                n_fail++; $display("FAIL reset_valid port%0d got %b want 0", p, dut_valid(p));
            end
            n_tests++;
            if (dut_data(p) !== 8'h00) begin
                n_fail++; $display("FAIL reset_data port%0d got %h want 00", p, dut_data(p));
            end
            n_tests++;
            if (dut_count(p) !== 8'h00) begin
                n_fail++; $display("FAIL reset_count port%0d got %h want 00", p, dut_count(p));
            end
        end
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_single_routes();
        logic [7:0] bytes [3];
        bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'hF0;
        b_ready = 1'b1; c_ready = 1'b1; d_ready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            s2 = (p == 2); s1 = (p != 0);
            in_data  = bytes[p];
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            for (int q = 0; q < 3; q++) begin
                n_tests++;
                if (dut_valid(q) !== (q == p)) begin
                    n_fail++; $display("FAIL route%0d_valid port%0d got %b want %b", p, q, dut_valid(q), (q == p));
                end
            end
            n_tests++;
            if (dut_data(p) !== bytes[p]) begin
                n_fail++; $display("FAIL route%0d_data got %h want %h", p, dut_data(p), bytes[p]);
            end
            tick();
            n_tests++;
            if (dut_valid(p) !== 1'b0 || dut_count(p) !== 8'd1) begin
                n_fail++; $display("FAIL route%0d_drain valid %b count %0d want 0/1", p, dut_valid(p), dut_count(p));
            end
        end
    endtask

    task automatic test_backpressure();
        pulse_reset();
        b_ready = 1'b0; c_ready = 1'b1; d_ready = 1'b0;
        s2 = 1'b1; s1 = 1'b0; in_data = 8'h11; in_valid = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_first_ready got %b want 1", in_ready);
        end
        tick();
        in_data = 8'h22;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_stall_ready got %b want 0", in_ready);
        end
        tick();
        n_tests++;
        if (d_valid !== 1'b1 || d_data !== 8'h11) begin
            n_fail++; $display("FAIL bp_hold got %b/%h want 1/11", d_valid, d_data);
        end
        // Byte to b while d is stalled
        s2 = 1'b0; s1 = 1'b0; in_data = 8'h77;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_b_ready got %b want 1", in_ready);
        end
        tick();
        n_tests++;
        if (b_valid !== 1'b1 || b_data !== 8'h77 || d_data !== 8'h11) begin
            n_fail++; $display("FAIL bp_b_accept got %b/%h d %h want 1/77 d 11", b_valid, b_data, d_data);
        end
        // Release d: 11 drains while 22 loads
        b_ready = 1'b1; d_ready = 1'b1;
        s2 = 1'b1; in_data = 8'h22;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release_ready got %b want 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (d_valid !== 1'b1 || d_data !== 8'h22 || d_count !== 8'd1 || b_count !== 8'd1) begin
            n_fail++; $display("FAIL bp_swap got %b/%h dcnt %0d bcnt %0d want 1/22 1 1", d_valid, d_data, d_count, b_count);
        end
        tick();
        n_tests++;
        if (d_valid !== 1'b0 || d_count !== 8'd2) begin
            n_fail++; $display("FAIL bp_final got %b cnt %0d want 0 2", d_valid, d_count);
        end
    endtask

    task automatic test_streaming();
        logic [7:0] sent;
        pulse_reset();
        b_ready = 1'b1; c_ready = 1'b1; d_ready = 1'b1;
        s2 = 1'b0; s1 = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            sent    = 8'($urandom);
            in_data = sent;
            #1;
            n_tests++;
            if (in_ready !== 1'b1) begin
                n_fail++; $display("FAIL stream_ready beat %0d got %b want 1", i, in_ready);
            end
            tick();
            n_tests++;
            if (c_valid !== 1'b1 || c_data !== sent) begin
                n_fail++; $display("FAIL stream_data beat %0d got %b/%h want 1/%h", i, c_valid, c_data, sent);
            end
        end
        in_valid = 1'b0;
        tick();
        n_tests++;
        if (c_count !== 8'd44 || b_valid !== 1'b0 || d_valid !== 1'b0) begin
            n_fail++; $display("FAIL stream_count got %0d bv %b dv %b want 44 0 0", c_count, b_valid, d_valid);
        end
    endtask

    task automatic test_clr_cnt();
        pulse_reset();
        b_ready = 1'b1; s2 = 1'b0; s1 = 1'b0;
        in_data = 8'h5A; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        n_tests++;
        if (b_count !== 8'd1) begin
            n_fail++; $display("FAIL clr_setup got %0d want 1", b_count);
        end
        b_ready = 1'b0; in_data = 8'h6B; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; b_ready = 1'b1; clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        n_tests++;
        if (b_count !== 8'd0 || b_valid !== 1'b0) begin
            n_fail++; $display("FAIL clr_same_cycle got %0d/%b want 0/0", b_count, b_valid);
        end
    endtask

    task automatic test_reset_mid();
        b_ready = 1'b0; c_ready = 1'b0; d_ready = 1'b0;
        s2 = 1'b0; s1 = 1'b0; in_data = 8'h12; in_valid = 1'b1;
        tick();
        s2 = 1'b1; in_data = 8'h34;
        tick();
        in_valid = 1'b0;
        n_tests++;
        if (b_valid !== 1'b1 || d_valid !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_setup got b %b d %b want 1 1", b_valid, d_valid);
        end
        reset = 1'b1; b_ready = 1'b1; d_ready = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++;
        if (b_valid !== 1'b0 || d_valid !== 1'b0 || b_count !== 8'd0 || d_count !== 8'd0) begin
            n_fail++; $display("FAIL rstmid got bv %b dv %b bc %0d dc %0d want 0 0 0 0", b_valid, d_valid, b_count, d_count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 79) == 0);
            clr_cnt  = ($urandom_range(0, 29) == 0);
            in_valid = 1'($urandom);
            s1       = 1'($urandom);
            s2       = 1'($urandom);
            in_data  = 8'($urandom);
            b_ready  = ($urandom_range(0, 3) != 0);
            c_ready  = ($urandom_range(0, 3) != 0);
            d_ready  = ($urandom_range(0, 1) != 0);
            #1;
            n_tests++;
            if (in_ready !== model_in_ready()) begin
                n_fail++; $display("FAIL rand_in_ready cycle %0d got %b want %b", i, in_ready, model_in_ready());
            end
            tick();
            for (int p = 0; p < 3; p++) begin
                n_tests++;
                if (dut_valid(p) !== m_full[p] || dut_data(p) !== m_data[p] || dut_count(p) !== 8'(m_cnt[p])) begin
                    n_fail++;
                    $display("FAIL rand_port%0d cycle %0d got %b/%h/%0d want %b/%h/%0d", p, i,
                             dut_valid(p), dut_data(p), dut_count(p), m_full[p], m_data[p], m_cnt[p]);
                end
            end
        end
        reset = 1'b0; clr_cnt = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_routes();
        test_backpressure();
        test_streaming();
        test_clr_cnt();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/demux8_bit_3_buf.md
Name: demux8_bit_3_buf

Overview:
Buffered 1-to-3 byte distributor: the inverse of the team's 8-bit three-way select mux. One producer byte stream is steered, per transfer, to one of three consumer ports (b, c, d) by the same s1/s2 select encoding the mux uses. Each output port has a one-entry holding register with a valid/ready handshake, plus a per-port transfer counter. It sits where a shared byte bus fans out to three consumers.

Parameters:
WIDTH, 8, data width of input and each output port
CNT_W, 8, width of each per-port transfer counter

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-high reset
in_data  input  WIDTH  byte offered by the producer
s1  input  1  select: route to c when s2=0
s2  input  1  select: route to d, overrides s1
in_valid  input  1  producer has a byte
in_ready  output  1  block accepts the byte this cycle
b_data / c_data / d_data  output  WIDTH each  holding-register contents
b_valid / c_valid / d_valid  output  1 each  holding register full
b_ready / c_ready / d_ready  input  1 each  consumer takes the byte
b_count / c_count / d_count  output  CNT_W each  completed output transfers per port
clr_cnt  input  1  synchronous clear of all three counters

Behaviour:
- Target decode: s2=1 -> d; s2=0,s1=1 -> c; s2=0,s1=0 -> b. Matches the mux (h = s2 ? d : s1 ? c : b).
- Reset, applied synchronously on any clk edge with reset=1: all *_valid=0, all *_data=0, all *_count=0. Reset mid-transfer discards buffered bytes. in_ready is combinational and may be high during reset, but no accept is recorded.
- in_ready = ~target_full | target_ready. The path is combinational from s1, s2 and the target's ready. The non-target ports do not affect it.
- Accept: an accept occurs when in_valid & in_ready & ~reset. At the next edge, the target register loads in_data and its valid is set. Latency from accept to out_valid is 1 cycle.
- Drain: a drain occurs when X_valid & X_ready. The register clears at the next edge unless it is reloaded in the same cycle.
- Simultaneous drain and accept on the same port: the new byte loads and valid stays 1. This gives full throughput of 1 byte/cycle per port.
- Accept to port X while port Y drains: both happen independently.
- X_data holds its value while X_valid=1 and X_ready=0. When a register is empty, its data is don't-care but must hold its last value (no X).
- Producer side: in_data and the select may change every cycle. Only the values present in the accept cycle matter. When in_valid=0, no state changes.
- Counters:
  - X_count increments on each drain of port X.
  - Counters wrap modulo 2^CNT_W, so 255 -> 0 at the default width.
  - clr_cnt forces all counters to 0 and wins over a same-cycle increment.
  - reset also clears the counters.
- Per-port state machine, two states: EMPTY and FULL.
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain without accept.
  - FULL -> FULL on drain with accept, or on stall.
- No ordering guarantee across ports. Within one port, order is preserved.

Decomposition:
- Shared package holds:
  - select constants SEL_B=2'b00, SEL_C=2'b01, SEL_D=2'b1x (encoded as {s2,s1});
  - default WIDTH/CNT_W.
- One sub-module, demux_slot: a one-entry holding register with load/valid/ready and its transfer counter. It is instantiated three times.
- The top level does the select decode and in_ready muxing only.

Test Plan:
- Reset check: reset=1 for 2 cycles with in_valid=1 -> all valid=0, data=0, counts=0, and no byte is captured.
- Single routes:
  - s2=0,s1=0, in_data=8'hA5, b_ready=1 -> b_valid=1, b_data=A5 next cycle, b_count=1;
  - s1=1 with 8'h3C -> lands on c only;
  - s2=1,s1=1 with 8'hF0 -> lands on d only.
- Backpressure: d_ready=0, send 8'h11 then 8'h22 to d -> 8'h11 held, in_ready=0 on the second beat. Raise d_ready -> 8'h11 drains, 8'h22 is accepted the same cycle, d_count ends at 2. Meanwhile a byte sent to b is accepted unaffected.
- Streaming: 300 back-to-back bytes to c with c_ready=1 -> every byte in order, one per cycle, c_count=300 mod 256 = 44.
- Counter clear: clr_cnt=1 in the same cycle as a b drain -> b_count=0 next cycle.
- Reset mid-operation: reset asserted while b and d are full -> both valid=0 next cycle, and no count increment for that cycle.
